// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: counter operations and
// the reset/allocate values of the direction counters.
package branch_target_buffer_pkg;

    // Widest direction counter the table supports.
    localparam int unsigned CNT_W_MAX = 3;

    // Per-entry direction counter command, decoded by the table update logic.
    typedef enum logic [1:0] {
        CntHold,
        CntInc,
        CntDec,
        CntLoad
    } cnt_op_e;

    // Weakly not-taken: one below the MSB threshold (0 for a 1-bit counter).
    function automatic int unsigned cnt_reset_val(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    // Weakly taken: MSB set, all lower bits clear.
    function automatic int unsigned cnt_alloc_val(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    // Entry layout, LSB first: target, counter, tag, valid.
    function automatic int unsigned entry_w(input int unsigned pc_w,
                                            input int unsigned tag_w,
                                            input int unsigned cnt_w);
        return pc_w + cnt_w + tag_w + 1;
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// CNT_W-wide up/down saturating counter with parallel load, one per BTB entry.
module branch_target_buffer_sat_counter
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned      CNT_W   = 2,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  cnt_op_e          i_op,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Next count: saturate at both ends, load overrides the current value.
    always_comb begin
        w_count_next = r_count;
        unique case (i_op)
            CntHold: w_count_next = r_count;
            CntInc:  w_count_next = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
            CntDec:  w_count_next = (r_count == '0) ? r_count : r_count - 1'b1;
            CntLoad: w_count_next = i_load_val;
        endcase
    end

    // Counter state register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_count <= RST_VAL;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with saturating direction
// counters. Lookup is combinational from stored state; updates from ID land
// on the clock edge. Saturating statistics count resolved branches.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_enable,
    input  logic [PC_W-1:0]   i_if_pc,
    output logic              o_pred_taken,
    output logic [PC_W-1:0]   o_pred_target,
    input  logic              i_upd_valid,
    input  logic [PC_W-1:0]   i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [PC_W-1:0]   i_upd_target,
    input  logic              i_upd_mispredict,
    input  logic              i_stat_clear,
    output logic [STAT_W-1:0] o_stat_lookups,
    output logic [STAT_W-1:0] o_stat_hits,
    output logic [STAT_W-1:0] o_stat_mispred
);

    localparam int unsigned      IDX_W     = $clog2(ENTRIES);
    localparam int unsigned      TAG_LO    = IDX_W + 2;
    localparam int unsigned      TAG_HI    = IDX_W + TAG_W + 1;
    localparam int unsigned      ENT_W     = entry_w(PC_W, TAG_W, CNT_W);
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(cnt_reset_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_alloc_val(CNT_W));

    // Flattened per-entry views of the table flops.
    logic             w_valid  [ENTRIES];
    logic [TAG_W-1:0] w_tag    [ENTRIES];
    logic [CNT_W-1:0] w_cnt    [ENTRIES];
    logic [PC_W-1:0]  w_target [ENTRIES];
    logic [ENT_W-1:0] w_entry  [ENTRIES];

    // Lookup side.
    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;

    assign w_lk_idx = i_if_pc[IDX_W+1:2];
    assign w_lk_tag = i_if_pc[TAG_HI:TAG_LO];
    assign w_lk_hit = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);

    // Prediction outputs straight from stored state (no update bypass).
    always_comb begin
        o_pred_taken  = w_lk_hit && w_cnt[w_lk_idx][CNT_W-1];
        o_pred_target = o_pred_taken ? w_target[w_lk_idx] : '0;
    end

    // Update side.
    logic             w_upd_go;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;

    assign w_upd_go  = i_enable && i_upd_valid;
    assign w_upd_idx = i_upd_pc[IDX_W+1:2];
    assign w_upd_tag = i_upd_pc[TAG_HI:TAG_LO];
    assign w_upd_hit = w_valid[w_upd_idx] && (w_tag[w_upd_idx] == w_upd_tag);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        logic             w_sel;
        cnt_op_e          w_op;
        logic             r_valid;
        logic [TAG_W-1:0] r_tag;
        logic [PC_W-1:0]  r_target;

        assign w_sel = w_upd_go && (w_upd_idx == IDX_W'(g));

        // Counter command: train on hit, weakly-taken load on taken miss.
        always_comb begin
            w_op = CntHold;
            if (w_sel) begin
                if (w_upd_hit) begin
                    w_op = i_upd_taken ? CntInc : CntDec;
                end else if (i_upd_taken) begin
                    w_op = CntLoad;
                end
            end
        end

        branch_target_buffer_sat_counter #(
            .CNT_W   (CNT_W),
            .RST_VAL (CNT_RST)
        ) u_cnt (
            .i_clk      (i_clk),
            .i_arst_n   (i_arst_n),
            .i_op       (w_op),
            .i_load_val (CNT_ALLOC),
            .o_count    (w_cnt[g])
        );

        // Valid/tag/target: refresh target on taken hit, allocate on taken miss.
        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                r_valid  <= 1'b0;
                r_tag    <= '0;
                r_target <= '0;
            end else if (w_sel && i_upd_taken) begin
                r_valid  <= 1'b1;
                r_tag    <= w_upd_tag;
                r_target <= i_upd_target;
            end
        end

        assign w_valid[g]  = r_valid;
        assign w_tag[g]    = r_tag;
        assign w_target[g] = r_target;
        assign w_entry[g]  = {r_valid, r_tag, w_cnt[g], r_target};
    end

    // Statistics.
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [STAT_W-1:0] r_stat_lookups;
    logic [STAT_W-1:0] r_stat_hits;
    logic [STAT_W-1:0] r_stat_mispred;

    // Saturating stat counters; clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
            r_stat_mispred <= '0;
        end else if (i_enable) begin
            if (i_stat_clear) begin
                r_stat_lookups <= '0;
                r_stat_hits    <= '0;
                r_stat_mispred <= '0;
            end else if (i_upd_valid) begin
                if (r_stat_lookups != STAT_MAX) begin
                    r_stat_lookups <= r_stat_lookups + 1'b1;
                end
                if (w_upd_hit && (r_stat_hits != STAT_MAX)) begin
                    r_stat_hits <= r_stat_hits + 1'b1;
                end
                if (i_upd_mispredict && (r_stat_mispred != STAT_MAX)) begin
                    r_stat_mispred <= r_stat_mispred + 1'b1;
                end
            end
        end
    end

    assign o_stat_lookups = r_stat_lookups;
    assign o_stat_hits    = r_stat_hits;
    assign o_stat_mispred = r_stat_mispred;

    // Low PC bits, high PC bits above the tag and the packed entry view are not consumed.
    logic w_unused;
    assign w_unused = ^{i_if_pc[1:0], i_if_pc[PC_W-1:TAG_HI+1],
                        i_upd_pc[1:0], i_upd_pc[PC_W-1:TAG_HI+1], w_entry[0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: lookup expectations go through a
// scoreboard queue; stats are checked against a small saturating model.
module tb_branch_target_buffer;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned STAT_W  = 2;
    localparam int          STAT_MAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              enable = 1'b0;
    logic [PC_W-1:0]   if_pc = '0;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic [PC_W-1:0]   upd_target = '0;
    logic              upd_mispredict = 1'b0;
    logic              stat_clear = 1'b0;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_hits;
    logic [STAT_W-1:0] stat_mispred;

    branch_target_buffer #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W),
        .STAT_W  (STAT_W)
    ) dut (
        .i_clk            (clk),
        .i_arst_n         (arst_n),
        .i_enable         (enable),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_upd_valid      (upd_valid),
        .i_upd_pc         (upd_pc),
        .i_upd_taken      (upd_taken),
        .i_upd_target     (upd_target),
        .i_upd_mispredict (upd_mispredict),
        .i_stat_clear     (stat_clear),
        .o_stat_lookups   (stat_lookups),
        .o_stat_hits      (stat_hits),
        .o_stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            taken;
        logic [PC_W-1:0] target;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_lookups = 0;
    int   m_hits    = 0;
    int   m_mispred = 0;

    function automatic int sat_inc(input int v);
        return (v >= STAT_MAX) ? STAT_MAX : v + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue expectation and drive PC now; pop and compare once the lookup settles.
    task automatic expect_push(input string name, input logic taken, input logic [PC_W-1:0] tgt);
        exp_t e;
        e.name = name;
        e.taken = taken;
        e.target = tgt;
        sb.push_back(e);
    endtask

    task automatic expect_pop();
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".taken"}, 64'(pred_taken), 64'(e.taken));
        check({e.name, ".target"}, pred_target, e.target);
    endtask

    task automatic lookup(input string name, input logic [PC_W-1:0] pc,
                          input logic taken, input logic [PC_W-1:0] tgt);
        if_pc = pc;
        expect_push(name, taken, tgt);
        #1;
        expect_pop();
    endtask

    task automatic model_update(input logic mis, input logic exp_hit);
        if (enable) begin
            if (stat_clear) begin
                m_lookups = 0;
                m_hits    = 0;
                m_mispred = 0;
            end else begin
                m_lookups = sat_inc(m_lookups);
                if (exp_hit) m_hits = sat_inc(m_hits);
                if (mis) m_mispred = sat_inc(m_mispred);
            end
        end
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic taken,
                       input logic [PC_W-1:0] tgt, input logic mis, input logic exp_hit);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_mispredict = mis;
        model_update(mis, exp_hit);
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic check_stats(input string name);
        check({name, ".lookups"}, 64'(stat_lookups), 64'(m_lookups));
        check({name, ".hits"}, 64'(stat_hits), 64'(m_hits));
        check({name, ".mispred"}, 64'(stat_mispred), 64'(m_mispred));
    endtask

    initial begin
        // Power-on reset.
        #12;
        lookup("rst_lookup", 64'h40, 1'b0, 64'h0);
        check_stats("rst_stats");
        arst_n = 1'b1;
        enable = 1'b1;
        step();

        // Allocate on taken miss, then probe an alias with a different tag.
        upd(64'h40, 1'b1, 64'h100, 1'b0, 1'b0);
        lookup("alloc", 64'h40, 1'b1, 64'h100);
        lookup("alias", 64'h40 + 4 * ENTRIES, 1'b0, 64'h0);

        // Hysteresis: 2 -> 1 -> 2 -> 3 -> 2 -> 1 -> 0.
        upd(64'h40, 1'b0, 64'h0, 1'b1, 1'b1);
        lookup("hyst_nt1", 64'h40, 1'b0, 64'h0);
        upd(64'h40, 1'b1, 64'h100, 1'b0, 1'b1);
        upd(64'h40, 1'b1, 64'h100, 1'b0, 1'b1);
        lookup("hyst_t2", 64'h40, 1'b1, 64'h100);
        upd(64'h40, 1'b0, 64'h0, 1'b0, 1'b1);
        lookup("hyst_nt_a", 64'h40, 1'b1, 64'h100);
        upd(64'h40, 1'b0, 64'h0, 1'b0, 1'b1);
        upd(64'h40, 1'b0, 64'h0, 1'b0, 1'b1);
        lookup("hyst_nt3", 64'h40, 1'b0, 64'h0);

        // Target refresh on taken hit: 0 -> 1 -> 2.
        upd(64'h40, 1'b1, 64'h200, 1'b0, 1'b1);
        lookup("retarget_weak", 64'h40, 1'b0, 64'h0);
        upd(64'h40, 1'b1, 64'h300, 1'b1, 1'b1);
        lookup("retarget", 64'h40, 1'b1, 64'h300);
        check_stats("stats_sat_a");

        // Clear wins over a same-cycle update.
        stat_clear = 1'b1;
        upd(64'h40, 1'b1, 64'h300, 1'b1, 1'b1);
        stat_clear = 1'b0;
        check_stats("stats_clear");

        // Five updates, two mispredicts on a fresh index.
        upd(64'h48, 1'b1, 64'h800, 1'b1, 1'b0);
        upd(64'h48, 1'b1, 64'h800, 1'b0, 1'b1);
        upd(64'h48, 1'b0, 64'h0,   1'b1, 1'b1);
        upd(64'h48, 1'b1, 64'h800, 1'b0, 1'b1);
        upd(64'h48, 1'b1, 64'h800, 1'b0, 1'b1);
        check_stats("stats_five");
        check("stats_five.lookups_sat", 64'(stat_lookups), 64'(STAT_MAX));
        check("stats_five.mispred_two", 64'(stat_mispred), 64'd2);
        lookup("idx2", 64'h48, 1'b1, 64'h800);

        // Same-cycle lookup and allocation at one index: old state this cycle.
        if_pc          = 64'h80;
        upd_valid      = 1'b1;
        upd_pc         = 64'h80;
        upd_taken      = 1'b1;
        upd_target     = 64'h444;
        upd_mispredict = 1'b0;
        model_update(1'b0, 1'b0);
        expect_push("same_cycle_pre", 1'b0, 64'h0);
        #1;
        expect_pop();
        step();
        upd_valid = 1'b0;
        lookup("same_cycle_post", 64'h80, 1'b1, 64'h444);
        lookup("evicted", 64'h40, 1'b0, 64'h0);

        // Frozen: neither the table nor the stats (nor clear) move.
        enable     = 1'b0;
        stat_clear = 1'b1;
        upd(64'hC0, 1'b1, 64'h999, 1'b1, 1'b0);
        stat_clear = 1'b0;
        step();
        check_stats("frozen_stats");
        lookup("frozen_tbl", 64'hC0, 1'b0, 64'h0);
        lookup("frozen_follow", 64'h80, 1'b1, 64'h444);
        enable = 1'b1;

        // Asynchronous reset mid-update aborts it and invalidates everything.
        if_pc          = 64'h80;
        upd_valid      = 1'b1;
        upd_pc         = 64'hC0;
        upd_taken      = 1'b1;
        upd_target     = 64'h555;
        upd_mispredict = 1'b1;
        #2;
        arst_n    = 1'b0;
        m_lookups = 0;
        m_hits    = 0;
        m_mispred = 0;
        lookup("midrst_lookup", 64'h80, 1'b0, 64'h0);
        check_stats("midrst_stats");
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        arst_n         = 1'b1;
        step();
        lookup("midrst_abort", 64'hC0, 1'b0, 64'h0);
        lookup("midrst_inval", 64'h48, 1'b0, 64'h0);
        check_stats("post_rst_stats");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
